ram_dump_reader: RTL and testbench
==================================

# ram_dump_reader

Sequential read-back engine for the on-chip program/data RAM: the reading counterpart of the RAM initialiser. It runs after reset-time initialisation. While it holds the RAM port, the top level muxes its address and read enable onto the RAM, the same way the init path is muxed. It walks an address window, returns each word with its address, and keeps a running 16-bit checksum. Words are delivered either streaming (one per clock) or single-stepped from the debounced Continue pulse, for display on HEX/LED.

## Interface
Parameters:
- ADDR_W, 10, RAM address width
- DATA_W, 16, RAM word width
- START_ADDR, 0, first address read (must be ≤ LAST_ADDR)
- LAST_ADDR, 1023, last address read, inclusive
- RD_LAT, 1, clock edges from the RAM address-capture edge to the edge where q is sampled (1 to 3)

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- Start  in  1  single-cycle pulse; begins a dump
- Step_mode  in  1  0 = stream, 1 = one word per Step; sampled only when Start is accepted
- Step  in  1  single-cycle pulse; requests the next word in step mode
- Mem_ADDR  out  ADDR_W  RAM address
- Mem_rden  out  1  RAM read enable
- Mem_q  in  DATA_W  RAM read data
- Busy  out  1  reader owns the RAM port; top-level mux select
- Word_out  out  DATA_W  captured word
- Word_addr  out  ADDR_W  address of Word_out
- Word_valid  out  1  one-cycle pulse per captured word
- Checksum  out  DATA_W  sum of captured words, mod 2^DATA_W
- Done  out  1  level; window complete

## Operation
- States: IDLE, STREAM, HOLD, WAIT, DONE.
- Reset from any state: go to IDLE and clear everything in flight.
  - All outputs are 0.
  - Mem_ADDR = START_ADDR.
- IDLE + Start:
  - Clear Checksum.
  - Load the issue counter with START_ADDR.
  - Latch Step_mode.
  - Go to STREAM (mode 0) or HOLD (mode 1).
  - Start and Step in the same cycle: Start wins, Step is ignored.
- STREAM:
  - Issue one read per cycle (Mem_rden = 1, Mem_ADDR = counter) and increment the counter.
  - After issuing LAST_ADDR, go to WAIT. No further reads are issued and the counter does not wrap.
- HOLD:
  - Mem_rden = 0.
  - Step issues one read, then go to WAIT.
  - Step pulses while that read is in flight are ignored (not queued).
- WAIT:
  - Drain the RD_LAT pipeline with no new reads.
  - In step mode, after the word lands: return to HOLD if more addresses remain, else go to DONE.
  - In stream mode: go to DONE after the last word lands.
- Each returning read:
  - Word_out ← Mem_q.
  - Word_addr ← the address issued with it, carried through the delay line.
  - Word_valid = 1 for one cycle.
  - Checksum ← Checksum + Mem_q, truncated to DATA_W bits (wraps, no saturation).
- DONE:
  - Done = 1, Busy = 0, Mem_rden = 0.
  - Word_out, Word_addr and Checksum hold their values.
  - Start restarts the dump (clears Checksum and Done). Step is ignored.
- Start in STREAM, HOLD or WAIT is ignored.
- Busy = 1 in STREAM, HOLD and WAIT.
- Single-address window (START_ADDR = LAST_ADDR): exactly one word, then DONE.

## Timing
- Start sampled at edge 0 → Busy = 1 and the first Mem_ADDR/Mem_rden are driven in the cycle after edge 0.
- RAM captures the address at edge 1.
- Mem_q is sampled at edge 1+RD_LAT → Word_valid is high in the cycle after that edge.
  - First Word_valid is RD_LAT+1 cycles after the Start edge.
- Stream mode: Word_valid is high on N = LAST_ADDR−START_ADDR+1 consecutive cycles, with no bubbles.
- Done rises, and Busy falls, the cycle after the last Word_valid cycle.
- Step mode: Step at edge s → Word_valid in the cycle after edge s+1+RD_LAT.
- Word_out, Word_addr and Checksum are registered and update on the same edge that raises Word_valid.
- Reset mid-dump discards in-flight reads: no Word_valid is produced after the Reset edge.

## Structure
- Package ram_reader_pkg:
  - rd_state_t enum {IDLE, STREAM, HOLD, WAIT, DONE}
  - localparam MAX_RD_LAT = 3
- Sub-module rd_lat_pipe: an RD_LAT-deep shift register of {valid, addr}, synchronous clear on Reset. The FSM, issue counter and checksum stay in the top of the block.

## Test plan
- Stream: RAM[i] = 3·i for i = 0..7, window 0..7, RD_LAT = 1.
  - Start → Word_valid on 8 consecutive cycles carrying addr 0..7 / data 0,3,…,21.
  - Checksum = 84; Done high the following cycle; Busy low.
- Step: same RAM, window 2..4, Step_mode = 1.
  - Each Step yields one word (6, 9, 12) two cycles later; Checksum = 27.
  - An extra Step pulse while a read is in flight yields no word.
  - After 3 words, Done = 1.
- Checksum wrap: RAM[0..3] = 0xFFFF → Checksum = 0xFFFC.
- Reset mid-stream: window 0..7, Reset asserted after the 3rd Word_valid.
  - The next cycle shows all outputs 0 and no further Word_valid.
  - A fresh Start re-dumps all 8 words with Checksum = 84.
- Start while Busy, Start+Step together in IDLE, and RD_LAT = 3:
  - Start while Busy: no restart, and the word sequence is unchanged.
  - Start+Step together in IDLE: Start is taken and Step is ignored.
  - RD_LAT = 3: first Word_valid 4 cycles after Start.

Source files
------------

// File: rtl/ram_reader_pkg.sv
// Shared types and constants for the RAM dump reader: FSM state encoding
// and read-latency limits.
package ram_reader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STREAM = 3'd1,
    HOLD   = 3'd2,
    WAIT   = 3'd3,
    DONE   = 3'd4
  } rd_state_t;

  localparam int MAX_RD_LAT = 3;

  // Keep the delay line between 1 and MAX_RD_LAT stages.
  function automatic int clamp_lat(input int lat);
    if (lat < 1) begin
      return 1;
    end else if (lat > MAX_RD_LAT) begin
      return MAX_RD_LAT;
    end else begin
      return lat;
    end
  endfunction

endpackage

// File: rtl/ram_dump_reader_rd_lat_pipe.sv
// Delay line that carries {valid, addr} of each issued read alongside the
// RAM's read latency, so returning data can be tagged with its address.
module rd_lat_pipe
  import ram_reader_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_addr
);

  localparam int DEPTH = clamp_lat(RD_LAT);

  logic [DEPTH-1:0]             r_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] r_addr;
  logic [DEPTH:0]               w_valid_chain;
  logic [DEPTH:0][ADDR_W-1:0]   w_addr_chain;

  // The top element of each chain is the oldest stage, i.e. the pipe output.
  assign w_valid_chain = {r_valid, i_valid};
  assign w_addr_chain  = {r_addr, i_addr};

  // Shift one stage per clock; a clear drops every read in flight.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_valid <= '0;
      r_addr  <= '0;
    end else begin
      r_valid <= w_valid_chain[DEPTH-1:0];
      r_addr  <= w_addr_chain[DEPTH-1:0];
    end
  end

  assign o_valid = w_valid_chain[DEPTH];
  assign o_addr  = w_addr_chain[DEPTH];

endmodule

// File: rtl/ram_dump_reader.sv
// Sequential RAM read-back engine: walks an address window, returns each
// word with its address and keeps a running checksum, streaming or stepped.
module ram_dump_reader
  import ram_reader_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 16,
  parameter int START_ADDR = 0,
  parameter int LAST_ADDR  = 1023,
  parameter int RD_LAT     = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Step_mode,
  input  logic              Step,
  output logic [ADDR_W-1:0] Mem_ADDR,
  output logic              Mem_rden,
  input  logic [DATA_W-1:0] Mem_q,
  output logic              Busy,
  output logic [DATA_W-1:0] Word_out,
  output logic [ADDR_W-1:0] Word_addr,
  output logic              Word_valid,
  output logic [DATA_W-1:0] Checksum,
  output logic              Done
);

  localparam logic [ADDR_W-1:0] C_START = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] C_LAST  = ADDR_W'(LAST_ADDR);

  rd_state_t         r_state;
  logic              r_step_mode;
  logic [ADDR_W-1:0] r_issue_addr;
  logic              r_mem_rden;
  logic              r_busy;
  logic              r_done;
  logic [DATA_W-1:0] r_word_out;
  logic [ADDR_W-1:0] r_word_addr;
  logic              r_word_valid;
  logic [DATA_W-1:0] r_checksum;
  logic              w_pipe_valid;
  logic [ADDR_W-1:0] w_pipe_addr;

  // A read enters the delay line on the edge where the RAM captures its address.
  rd_lat_pipe #(
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT)
  ) u_pipe (
    .Clk     (Clk),
    .Reset   (Reset),
    .i_valid (r_mem_rden),
    .i_addr  (r_issue_addr),
    .o_valid (w_pipe_valid),
    .o_addr  (w_pipe_addr)
  );

  // Reader FSM, issue counter, word capture and checksum.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= IDLE;
      r_step_mode  <= 1'b0;
      r_issue_addr <= C_START;
      r_mem_rden   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_word_out   <= '0;
      r_word_addr  <= '0;
      r_word_valid <= 1'b0;
      r_checksum   <= '0;
    end else begin
      r_word_valid <= w_pipe_valid;
      if (w_pipe_valid) begin
        r_word_out  <= Mem_q;
        r_word_addr <= w_pipe_addr;
        r_checksum  <= r_checksum + Mem_q;
      end else begin
        r_word_out  <= r_word_out;
        r_word_addr <= r_word_addr;
        r_checksum  <= r_checksum;
      end

      case (r_state)
        IDLE, DONE: begin
          r_mem_rden <= 1'b0;
          if (Start) begin
            r_checksum   <= '0;
            r_done       <= 1'b0;
            r_busy       <= 1'b1;
            r_issue_addr <= C_START;
            r_step_mode  <= Step_mode;
            if (Step_mode) begin
              r_state <= HOLD;
            end else begin
              r_state    <= STREAM;
              r_mem_rden <= 1'b1;
            end
          end else begin
            r_state <= r_state;
          end
        end

        // The address on the port now is captured by the RAM at this edge.
        STREAM: begin
          if (r_issue_addr == C_LAST) begin
            r_mem_rden <= 1'b0;
            r_state    <= WAIT;
          end else begin
            r_mem_rden   <= 1'b1;
            r_issue_addr <= r_issue_addr + 1'b1;
          end
        end

        HOLD: begin
          if (Step) begin
            r_mem_rden <= 1'b1;
            r_state    <= WAIT;
          end else begin
            r_mem_rden <= 1'b0;
          end
        end

        // Leave only once the landed word is visible, so Done trails it by one cycle.
        WAIT: begin
          r_mem_rden <= 1'b0;
          if (r_word_valid && (r_word_addr == C_LAST)) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else if (r_word_valid && r_step_mode) begin
            r_state      <= HOLD;
            r_issue_addr <= r_issue_addr + 1'b1;
          end else begin
            r_state <= WAIT;
          end
        end

        default: begin
          r_state    <= IDLE;
          r_mem_rden <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign Mem_ADDR   = r_issue_addr;
  assign Mem_rden   = r_mem_rden;
  assign Busy       = r_busy;
  assign Word_out   = r_word_out;
  assign Word_addr  = r_word_addr;
  assign Word_valid = r_word_valid;
  assign Checksum   = r_checksum;
  assign Done       = r_done;

endmodule

// File: tb/tb_ram_dump_reader.sv
// Directed scoreboard bench for ram_dump_reader: four instances covering
// stream, step mode, checksum wrap and a three-cycle read latency.
module tb_ram_dump_reader;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        rst[4];
  logic        start[4];
  logic        mode[4];
  logic        step[4];
  logic [9:0]  maddr[4];
  logic        mrden[4];
  logic [15:0] mq[4];
  logic        busy[4];
  logic [15:0] wout[4];
  logic [9:0]  waddr[4];
  logic        wv[4];
  logic [15:0] csum[4];
  logic        done[4];

  logic [15:0] ram[1024];
  logic [15:0] qp[4][3];
  logic [25:0] sbq[$];
  logic [15:0] exp_sum;
  int          active;
  int          n_assert;
  int          n_fail;
  int          f_c, n_w, l_c, d_c;

  // RAM model: registered read, extra output stages give the longer latency.
  always @(posedge Clk) begin
    for (int k = 0; k < 4; k++) begin
      if (mrden[k]) qp[k][0] <= ram[maddr[k]];
      qp[k][1] <= qp[k][0];
      qp[k][2] <= qp[k][1];
    end
  end
  assign mq[0] = qp[0][0];
  assign mq[1] = qp[1][0];
  assign mq[2] = qp[2][0];
  assign mq[3] = qp[3][2];

  ram_dump_reader #(.START_ADDR(0), .LAST_ADDR(7), .RD_LAT(1)) u0 (
    .Clk(Clk), .Reset(rst[0]), .Start(start[0]), .Step_mode(mode[0]), .Step(step[0]),
    .Mem_ADDR(maddr[0]), .Mem_rden(mrden[0]), .Mem_q(mq[0]), .Busy(busy[0]),
    .Word_out(wout[0]), .Word_addr(waddr[0]), .Word_valid(wv[0]), .Checksum(csum[0]), .Done(done[0]));
  ram_dump_reader #(.START_ADDR(2), .LAST_ADDR(4), .RD_LAT(1)) u1 (
    .Clk(Clk), .Reset(rst[1]), .Start(start[1]), .Step_mode(mode[1]), .Step(step[1]),
    .Mem_ADDR(maddr[1]), .Mem_rden(mrden[1]), .Mem_q(mq[1]), .Busy(busy[1]),
    .Word_out(wout[1]), .Word_addr(waddr[1]), .Word_valid(wv[1]), .Checksum(csum[1]), .Done(done[1]));
  ram_dump_reader #(.START_ADDR(0), .LAST_ADDR(3), .RD_LAT(1)) u2 (
    .Clk(Clk), .Reset(rst[2]), .Start(start[2]), .Step_mode(mode[2]), .Step(step[2]),
    .Mem_ADDR(maddr[2]), .Mem_rden(mrden[2]), .Mem_q(mq[2]), .Busy(busy[2]),
    .Word_out(wout[2]), .Word_addr(waddr[2]), .Word_valid(wv[2]), .Checksum(csum[2]), .Done(done[2]));
  ram_dump_reader #(.START_ADDR(0), .LAST_ADDR(7), .RD_LAT(3)) u3 (
    .Clk(Clk), .Reset(rst[3]), .Start(start[3]), .Step_mode(mode[3]), .Step(step[3]),
    .Mem_ADDR(maddr[3]), .Mem_rden(mrden[3]), .Mem_q(mq[3]), .Busy(busy[3]),
    .Word_out(wout[3]), .Word_addr(waddr[3]), .Word_valid(wv[3]), .Checksum(csum[3]), .Done(done[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and score every Word_valid against the expected queue.
  task automatic tick();
    logic [25:0] e;
    @(negedge Clk);
    for (int k = 0; k < 4; k++) begin
      if (wv[k]) begin
        check("wv_owner", 32'(k), 32'(active));
        check("sb_pending", 32'(sbq.size() > 0), 32'd1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          exp_sum = exp_sum + e[15:0];
          check("word_addr", 32'(waddr[k]), 32'(e[25:16]));
          check("word_out", 32'(wout[k]), 32'(e[15:0]));
          check("checksum_run", 32'(csum[k]), 32'(exp_sum));
        end
      end
    end
  endtask

  task automatic push_word(input int a);
    sbq.push_back({10'(a), ram[10'(a)]});
  endtask

  // Stream dump; poke re-asserts Start at that cycle index while busy.
  task automatic run_dump(input int k, input int lo, input int hi, input int poke,
                          output int first_c, output int nw, output int last_c, output int done_c);
    active = k;
    exp_sum = 16'd0;
    for (int a = lo; a <= hi; a++) push_word(a);
    first_c = -1; nw = 0; last_c = -1; done_c = -1;
    start[k] = 1'b1;
    mode[k] = 1'b0;
    for (int c = 0; c < 60 && done_c < 0; c++) begin
      tick();
      start[k] = (c + 1 == poke);
      if (c == 0) begin
        check("start_busy", 32'(busy[k]), 32'd1);
        check("start_rden", 32'(mrden[k]), 32'd1);
        check("start_maddr", 32'(maddr[k]), 32'(lo));
      end
      if (wv[k]) begin
        if (first_c < 0) first_c = c;
        nw++;
        last_c = c;
      end
      if (done[k]) begin
        done_c = c;
        check("done_busy", 32'(busy[k]), 32'd0);
      end
    end
    start[k] = 1'b0;
    check("sb_drained", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    n_assert = 0;
    n_fail = 0;
    active = -1;
    exp_sum = 16'd0;
    for (int k = 0; k < 4; k++) begin
      rst[k] = 1'b1; start[k] = 1'b0; mode[k] = 1'b0; step[k] = 1'b0;
    end
    for (int i = 0; i < 1024; i++) ram[10'(i)] = 16'(3 * i);
    tick(); tick();
    for (int k = 0; k < 4; k++) rst[k] = 1'b0;
    tick();

    check("rst_busy", 32'(busy[0]), 32'd0);
    check("rst_done", 32'(done[0]), 32'd0);
    check("rst_wv", 32'(wv[0]), 32'd0);
    check("rst_csum", 32'(csum[0]), 32'd0);
    check("rst_wout", 32'(wout[0]), 32'd0);
    check("rst_rden", 32'(mrden[0]), 32'd0);
    check("rst_maddr_u1", 32'(maddr[1]), 32'd2);

    // Plain stream of window 0..7.
    run_dump(0, 0, 7, -1, f_c, n_w, l_c, d_c);
    check("s_first", 32'(f_c), 32'd2);
    check("s_count", 32'(n_w), 32'd8);
    check("s_last", 32'(l_c), 32'd9);
    check("s_done_cyc", 32'(d_c), 32'd10);
    check("s_csum", 32'(csum[0]), 32'd84);

    // Restart from DONE, with a Start pulse mid-stream that must be ignored.
    run_dump(0, 0, 7, 3, f_c, n_w, l_c, d_c);
    check("sb_first", 32'(f_c), 32'd2);
    check("sb_count", 32'(n_w), 32'd8);
    check("sb_done_cyc", 32'(d_c), 32'd10);
    check("sb_csum", 32'(csum[0]), 32'd84);

    // Reset after the third word.
    active = 0;
    exp_sum = 16'd0;
    for (int a = 0; a <= 7; a++) push_word(a);
    start[0] = 1'b1;
    n_w = 0;
    for (int c = 0; c < 20 && n_w < 3; c++) begin
      tick();
      start[0] = 1'b0;
      if (wv[0]) n_w++;
    end
    check("mr_words", 32'(n_w), 32'd3);
    rst[0] = 1'b1;
    sbq.delete();
    tick();
    rst[0] = 1'b0;
    check("mr_wv", 32'(wv[0]), 32'd0);
    check("mr_busy", 32'(busy[0]), 32'd0);
    check("mr_done", 32'(done[0]), 32'd0);
    check("mr_csum", 32'(csum[0]), 32'd0);
    check("mr_wout", 32'(wout[0]), 32'd0);
    check("mr_waddr", 32'(waddr[0]), 32'd0);
    check("mr_rden", 32'(mrden[0]), 32'd0);
    check("mr_maddr", 32'(maddr[0]), 32'd0);
    repeat (6) tick();
    check("mr_idle_busy", 32'(busy[0]), 32'd0);
    run_dump(0, 0, 7, -1, f_c, n_w, l_c, d_c);
    check("mr_redump_count", 32'(n_w), 32'd8);
    check("mr_redump_csum", 32'(csum[0]), 32'd84);

    // Step mode on window 2..4; second step gets an extra Step while in flight.
    active = 1;
    exp_sum = 16'd0;
    start[1] = 1'b1; mode[1] = 1'b1;
    tick();
    start[1] = 1'b0; mode[1] = 1'b0;
    check("st_busy", 32'(busy[1]), 32'd1);
    check("st_rden", 32'(mrden[1]), 32'd0);
    tick(); tick();
    check("st_hold_nowv", 32'(wv[1]), 32'd0);
    for (int w = 0; w < 3; w++) begin
      push_word(2 + w);
      step[1] = 1'b1;
      tick();
      step[1] = (w == 1);
      tick();
      step[1] = 1'b0;
      tick();
      check("st_wv", 32'(wv[1]), 32'd1);
      tick();
      check("st_done", 32'(done[1]), 32'(w == 2));
      tick();
    end
    check("st_csum", 32'(csum[1]), 32'd27);
    check("st_busy_end", 32'(busy[1]), 32'd0);
    check("st_sb_drained", 32'(sbq.size()), 32'd0);
    step[1] = 1'b1;
    tick();
    step[1] = 1'b0;
    repeat (3) tick();
    check("st_done_hold", 32'(done[1]), 32'd1);
    check("st_csum_hold", 32'(csum[1]), 32'd27);

    // Start and Step together in IDLE: Start taken, Step ignored.
    rst[1] = 1'b1;
    tick();
    rst[1] = 1'b0;
    tick();
    start[1] = 1'b1; mode[1] = 1'b1; step[1] = 1'b1;
    tick();
    start[1] = 1'b0; mode[1] = 1'b0; step[1] = 1'b0;
    check("ss_busy", 32'(busy[1]), 32'd1);
    check("ss_rden", 32'(mrden[1]), 32'd0);
    repeat (4) tick();
    check("ss_still_busy", 32'(busy[1]), 32'd1);
    check("ss_no_done", 32'(done[1]), 32'd0);
    rst[1] = 1'b1;
    tick();
    rst[1] = 1'b0;

    // Three-cycle read latency.
    run_dump(3, 0, 7, -1, f_c, n_w, l_c, d_c);
    check("l3_first", 32'(f_c), 32'd4);
    check("l3_count", 32'(n_w), 32'd8);
    check("l3_done_cyc", 32'(d_c), 32'd12);
    check("l3_csum", 32'(csum[3]), 32'd84);

    // Checksum wrap on window 0..3.
    for (int i = 0; i < 4; i++) ram[10'(i)] = 16'hFFFF;
    run_dump(2, 0, 3, -1, f_c, n_w, l_c, d_c);
    check("wr_count", 32'(n_w), 32'd4);
    check("wr_done_cyc", 32'(d_c), 32'd6);
    check("wr_csum", 32'(csum[2]), 32'h0000FFFC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
